// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 command transmitter: inhibit, request-to-send, 11-bit frame, ACK check, line release.
// Line inputs are seen 3 clk after they change; i_start is dropped (not queued) unless idle, and only one command is in flight at a time.
module ps2_host_tx #(
    parameter int unsigned INHIBIT_CYCLES = 5000,
    parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_ps2_clk,
    input  logic       i_ps2_data,
    input  logic       i_start,
    input  logic [7:0] i_byte,
    output logic       o_clk_oe,
    output logic       o_data_oe,
    output logic       o_busy,
    output logic       o_done,
    output logic       o_error
);
    localparam int IW = $clog2(INHIBIT_CYCLES + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [IW-1:0] INH_LAST = IW'(INHIBIT_CYCLES - 1);
    localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_INHIBIT, S_RTS, S_SEND, S_ACK, S_RELEASE
    } state_t;

    state_t        r_state;
    logic [IW-1:0] r_inh_cnt;
    logic [TW-1:0] r_to_cnt;
    logic [9:0]    r_shift;
    logic [3:0]    r_bit_cnt;
    logic          r_err;
    logic          r_clk_oe, r_data_oe, r_busy, r_done, r_error;
    logic          r_clk_s1, r_clk_s2, r_clk_prev;
    logic          r_dat_s1, r_dat_s2;

    logic w_fall, w_active, w_timeout;

    assign w_fall    = r_clk_prev & ~r_clk_s2;
    assign w_active  = (r_state == S_RTS) || (r_state == S_SEND) ||
                       (r_state == S_ACK) || (r_state == S_RELEASE);
    assign w_timeout = w_active && (r_to_cnt == TO_LAST);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_inh_cnt  <= '0;
            r_to_cnt   <= '0;
            r_shift    <= '0;
            r_bit_cnt  <= '0;
            r_err      <= 1'b0;
            r_clk_oe   <= 1'b0;
            r_data_oe  <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_error    <= 1'b0;
            r_clk_s1   <= 1'b1;
            r_clk_s2   <= 1'b1;
            r_clk_prev <= 1'b1;
            r_dat_s1   <= 1'b1;
            r_dat_s2   <= 1'b1;
        end else begin
            r_clk_s1   <= i_ps2_clk;
            r_clk_s2   <= r_clk_s1;
            r_clk_prev <= r_clk_s2;
            r_dat_s1   <= i_ps2_data;
            r_dat_s2   <= r_dat_s1;
            r_done     <= 1'b0;
            r_error    <= 1'b0;
            if (w_active) r_to_cnt <= r_to_cnt + 1'b1;

            // Expiry takes priority over any edge arriving in the same cycle.
            if (w_timeout) begin
                r_clk_oe  <= 1'b0;
                r_data_oe <= 1'b0;
                r_done    <= 1'b1;
                r_error   <= 1'b1;
                r_state   <= S_IDLE;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        r_busy    <= 1'b0;
                        r_clk_oe  <= 1'b0;
                        r_data_oe <= 1'b0;
                        // r_done still high means the previous command is ending this cycle.
                        if (i_start && !r_done) begin
                            r_shift   <= {1'b1, ~^i_byte, i_byte};
                            r_inh_cnt <= '0;
                            r_err     <= 1'b0;
                            r_clk_oe  <= 1'b1;
                            r_busy    <= 1'b1;
                            r_state   <= S_INHIBIT;
                        end
                    end
                    S_INHIBIT: begin
                        if (r_inh_cnt == INH_LAST) begin
                            r_clk_oe  <= 1'b0;
                            r_data_oe <= 1'b1;
                            r_to_cnt  <= '0;
                            r_state   <= S_RTS;
                        end else begin
                            r_inh_cnt <= r_inh_cnt + 1'b1;
                        end
                    end
                    S_RTS: begin
                        if (w_fall) begin
                            r_data_oe <= ~r_shift[0];
                            r_shift   <= {1'b0, r_shift[9:1]};
                            r_bit_cnt <= 4'd1;
                            r_state   <= S_SEND;
                        end
                    end
                    S_SEND: begin
                        if (w_fall) begin
                            r_data_oe <= ~r_shift[0];
                            r_shift   <= {1'b0, r_shift[9:1]};
                            r_bit_cnt <= r_bit_cnt + 1'b1;
                            if (r_bit_cnt == 4'd9) r_state <= S_ACK;
                        end
                    end
                    S_ACK: begin
                        if (w_fall) begin
                            r_err   <= r_dat_s2;
                            r_state <= S_RELEASE;
                        end
                    end
                    S_RELEASE: begin
                        if (r_clk_s2 && r_dat_s2) begin
                            r_done  <= 1'b1;
                            r_error <= r_err;
                            r_state <= S_IDLE;
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    assign o_clk_oe  = r_clk_oe;
    assign o_data_oe = r_data_oe;
    assign o_busy    = r_busy;
    assign o_done    = r_done;
    assign o_error   = r_error;
endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx with an open-drain line model and a device clocking at clk/200.
module tb_ps2_host_tx;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       i_start = 1'b0;
    logic [7:0] i_byte = 8'h00;
    logic       o_clk_oe, o_data_oe, o_busy, o_done, o_error;
    logic       dev_clk_low = 1'b0;
    logic       dev_dat_low = 1'b0;
    logic       ps2_clk_line, ps2_dat_line;
    int         n_checks = 0;
    int         n_fail = 0;
    int         done_cnt = 0;

    assign ps2_clk_line = ~(o_clk_oe | dev_clk_low);
    assign ps2_dat_line = ~(o_data_oe | dev_dat_low);

    always #5 clk = ~clk;

    ps2_host_tx #(.INHIBIT_CYCLES(20), .TIMEOUT_CYCLES(4000)) dut (
        .clk(clk), .rst_n(rst_n), .i_ps2_clk(ps2_clk_line), .i_ps2_data(ps2_dat_line),
        .i_start(i_start), .i_byte(i_byte), .o_clk_oe(o_clk_oe), .o_data_oe(o_data_oe),
        .o_busy(o_busy), .o_done(o_done), .o_error(o_error)
    );

    always @(negedge clk) if (o_done === 1'b1) done_cnt++;

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        tick(3);
        n_checks++; if (o_clk_oe !== 1'b0) begin n_fail++; $display("FAIL reset_clk_oe got %b want 0", o_clk_oe); end
        n_checks++; if (o_data_oe !== 1'b0) begin n_fail++; $display("FAIL reset_data_oe got %b want 0", o_data_oe); end
        n_checks++; if (o_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", o_busy); end
        n_checks++; if (o_done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", o_done); end
        n_checks++; if (o_error !== 1'b0) begin n_fail++; $display("FAIL reset_error got %b want 0", o_error); end
        rst_n = 1'b1;
        tick(2);
    endtask

    // Pulses i_start and checks the inhibit window length and the RTS that follows.
    task automatic begin_tx(input logic [7:0] b, input string tag);
        int cnt;
        @(negedge clk);
        i_start = 1'b1; i_byte = b;
        @(negedge clk);
        i_start = 1'b0; i_byte = 8'h5A;
        n_checks++; if (o_busy !== 1'b1) begin n_fail++; $display("FAIL %s busy_after_start got %b want 1", tag, o_busy); end
        cnt = 0;
        while (o_clk_oe === 1'b1 && cnt < 100) begin cnt++; @(negedge clk); end
        n_checks++; if (cnt !== 20) begin n_fail++; $display("FAIL %s inhibit_len got %0d want 20", tag, cnt); end
        n_checks++; if (o_data_oe !== 1'b1 || o_clk_oe !== 1'b0)
            begin n_fail++; $display("FAIL %s rts got clk_oe=%b data_oe=%b want 0/1", tag, o_clk_oe, o_data_oe); end
    endtask

    // Device: wait for RTS, sample start bit, then nbits clock pulses sampling on each rising edge.
    task automatic dev_bits(input int nbits, output logic [10:0] smp);
        int k;
        smp = '0;
        k = 0;
        while (!(ps2_clk_line === 1'b1 && ps2_dat_line === 1'b0) && k < 1000) begin @(negedge clk); k++; end
        if (k >= 1000) begin n_checks++; n_fail++; $display("FAIL dev_rts_wait got no RTS want RTS within 1000"); end
        tick(50);
        smp[0] = ps2_dat_line;
        for (int i = 1; i <= nbits; i++) begin
            dev_clk_low = 1'b1;
            tick(100);
            dev_clk_low = 1'b0;
            smp[i] = ps2_dat_line;
            tick(100);
        end
    endtask

    task automatic dev_ack(input bit ack);
        dev_dat_low = ack;
        tick(50);
        dev_clk_low = 1'b1;
        tick(100);
        dev_clk_low = 1'b0;
        dev_dat_low = 1'b0;
    endtask

    task automatic wait_done(input logic exp_err, input string tag);
        int k;
        k = 0;
        while (o_done !== 1'b1 && k < 500) begin @(negedge clk); k++; end
        if (k >= 500) begin
            n_checks++; n_fail++; $display("FAIL %s done_wait got no done want done within 500", tag);
        end else begin
            n_checks++; if (o_error !== exp_err) begin n_fail++; $display("FAIL %s error got %b want %b", tag, o_error, exp_err); end
            n_checks++; if (o_busy !== 1'b1) begin n_fail++; $display("FAIL %s busy_at_done got %b want 1", tag, o_busy); end
            tick(1);
            n_checks++; if (o_busy !== 1'b0) begin n_fail++; $display("FAIL %s busy_after_done got %b want 0", tag, o_busy); end
            n_checks++; if (o_done !== 1'b0) begin n_fail++; $display("FAIL %s done_width got %b want 0", tag, o_done); end
            n_checks++; if (o_clk_oe !== 1'b0 || o_data_oe !== 1'b0)
                begin n_fail++; $display("FAIL %s lines_after got %b%b want 00", tag, o_clk_oe, o_data_oe); end
        end
    endtask

    task automatic test_send(input logic [7:0] b, input logic [10:0] exp_frame, input string tag);
        logic [10:0] smp;
        int d0;
        d0 = done_cnt;
        begin_tx(b, tag);
        dev_bits(10, smp);
        n_checks++; if (smp !== exp_frame) begin n_fail++; $display("FAIL %s frame got %h want %h", tag, smp, exp_frame); end
        dev_ack(1'b1);
        wait_done(1'b0, tag);
        tick(20);
        n_checks++; if (done_cnt !== d0 + 1) begin n_fail++; $display("FAIL %s done_count got %0d want %0d", tag, done_cnt - d0, 1); end
    endtask

    task automatic test_nack;
        logic [10:0] smp;
        begin_tx(8'hFF, "nack");
        dev_bits(10, smp);
        n_checks++; if (smp !== 11'h7FE) begin n_fail++; $display("FAIL nack frame got %h want 7fe", smp); end
        dev_ack(1'b0);
        wait_done(1'b1, "nack");
    endtask

    task automatic test_timeout;
        int k, d0;
        d0 = done_cnt;
        begin_tx(8'hF4, "timeout");
        k = 0;
        while (o_done !== 1'b1 && k < 5000) begin @(negedge clk); k++; end
        n_checks++; if (k !== 4000) begin n_fail++; $display("FAIL timeout latency got %0d want 4000", k); end
        n_checks++; if (o_error !== 1'b1) begin n_fail++; $display("FAIL timeout error got %b want 1", o_error); end
        n_checks++; if (o_data_oe !== 1'b0 || o_clk_oe !== 1'b0)
            begin n_fail++; $display("FAIL timeout lines got %b%b want 00", o_clk_oe, o_data_oe); end
        tick(10);
        n_checks++; if (o_busy !== 1'b0) begin n_fail++; $display("FAIL timeout busy_after got %b want 0", o_busy); end
        n_checks++; if (done_cnt !== d0 + 1) begin n_fail++; $display("FAIL timeout done_count got %0d want 1", done_cnt - d0); end
    endtask

    task automatic test_back_to_back;
        logic [10:0] smp;
        int d0;
        d0 = done_cnt;
        begin_tx(8'hF4, "ignore_start");
        fork
            dev_bits(10, smp);
            begin
                tick(700);
                n_checks++; if (o_busy !== 1'b1) begin n_fail++; $display("FAIL ignore_start busy_mid got %b want 1", o_busy); end
                i_start = 1'b1; i_byte = 8'hFF;
                tick(1);
                i_start = 1'b0; i_byte = 8'h00;
            end
        join
        n_checks++; if (smp !== 11'h5E8) begin n_fail++; $display("FAIL ignore_start frame got %h want 5e8", smp); end
        dev_ack(1'b1);
        wait_done(1'b0, "ignore_start");
        tick(30);
        n_checks++; if (done_cnt !== d0 + 1) begin n_fail++; $display("FAIL ignore_start done_count got %0d want 1", done_cnt - d0); end
        n_checks++; if (o_busy !== 1'b0 || o_clk_oe !== 1'b0)
            begin n_fail++; $display("FAIL ignore_start queued got busy=%b clk_oe=%b want 0/0", o_busy, o_clk_oe); end
    endtask

    task automatic test_reset_mid;
        logic [10:0] smp;
        int d0;
        d0 = done_cnt;
        begin_tx(8'hF4, "reset_mid");
        dev_bits(5, smp);
        n_checks++; if (smp[5:0] !== 6'h28) begin n_fail++; $display("FAIL reset_mid partial got %h want 28", smp[5:0]); end
        rst_n = 1'b0;
        tick(1);
        n_checks++; if (o_clk_oe !== 1'b0 || o_data_oe !== 1'b0)
            begin n_fail++; $display("FAIL reset_mid lines got %b%b want 00", o_clk_oe, o_data_oe); end
        n_checks++; if (o_busy !== 1'b0) begin n_fail++; $display("FAIL reset_mid busy got %b want 0", o_busy); end
        rst_n = 1'b1;
        tick(50);
        n_checks++; if (done_cnt !== d0) begin n_fail++; $display("FAIL reset_mid done_count got %0d want 0", done_cnt - d0); end
        test_send(8'h5A, 11'h6B4, "after_reset");
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog got no finish want finish before 3 ms");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_send(8'hF4, 11'h5E8, "send_f4");
        test_send(8'h00, 11'h600, "send_00");
        test_send(8'hFF, 11'h7FE, "send_ff");
        test_nack();
        test_timeout();
        test_back_to_back();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
